// File: rtl/cmd_mem_array.sv
// cmd_mem_array: per-core command memories loaded by a multi-beat host stream and committed
// atomically. Define CMD_MEM_READBACK_EN to add the host readback port (rb_*).
module cmd_mem_array #(
   parameter int unsigned NUM_CORES      = 2,
   parameter int unsigned CORE_ID_WIDTH  = 1,
   parameter int unsigned CMD_ADDR_WIDTH = 8,
   parameter int unsigned MEM_WIDTH      = 32,
   parameter int unsigned MEM_TO_CMD     = 4,
   parameter int unsigned READ_LATENCY   = 1,
   localparam int unsigned CMD_WIDTH     = MEM_WIDTH * MEM_TO_CMD,
   localparam int unsigned SEL_W         = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   input  logic [CORE_ID_WIDTH-1:0]            wr_core,
   input  logic [CMD_ADDR_WIDTH-1:0]           wr_addr,
   input  logic [MEM_WIDTH-1:0]                wr_data,
   input  logic                                wr_last,
   output logic                                err,
   input  logic                                err_clear,
`ifdef CMD_MEM_READBACK_EN
   input  logic                                rb_req,
   input  logic [CORE_ID_WIDTH-1:0]            rb_core,
   input  logic [CMD_ADDR_WIDTH-1:0]           rb_addr,
   input  logic [SEL_W-1:0]                    rb_sel,
   output logic [MEM_WIDTH-1:0]                rb_data,
   output logic                                rb_valid,
`endif
   input  logic [NUM_CORES*CMD_ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CORES*CMD_WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH    = 2 ** CMD_ADDR_WIDTH;
   localparam int unsigned ID_SPACE = 2 ** CORE_ID_WIDTH;

   typedef enum logic [0:0] {StAccum, StCommit} state_e;

   state_e                                state_q, state_d;
   logic [SEL_W-1:0]                      beat_q, beat_d;
   logic [MEM_TO_CMD-1:0][MEM_WIDTH-1:0]  stage_q, stage_d;
   logic [CORE_ID_WIDTH-1:0]              core_q, core_d;
   logic [CMD_ADDR_WIDTH-1:0]             addr_q, addr_d;
   logic                                  err_q, err_d;
   logic                                  err_set;
   logic                                  commit;
   logic [CORE_ID_WIDTH-1:0]              eff_core;
   logic [ID_SPACE-1:0]                   core_ok;

   for (genvar i = 0; i < ID_SPACE; i++) begin : g_core_ok
      assign core_ok[i] = (i < NUM_CORES);
   end

   // On a single-beat command the core is still on the bus, not yet latched.
   assign eff_core = (beat_q == '0) ? wr_core : core_q;
   assign wr_ready = (state_q == StAccum);
   assign err      = err_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      stage_d = stage_q;
      core_d  = core_q;
      addr_d  = addr_q;
      err_set = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StAccum: begin
            if (wr_valid) begin
               stage_d[beat_q] = wr_data;
               if (beat_q == '0) begin
                  core_d = wr_core;
                  addr_d = wr_addr;
               end
               if (beat_q == SEL_W'(MEM_TO_CMD - 1)) begin
                  beat_d = '0;
                  if (wr_last && core_ok[eff_core]) begin
                     state_d = StCommit;
                  end else begin
                     err_set = 1'b1;
                  end
               end else if (wr_last) begin
                  beat_d  = '0;
                  err_set = 1'b1;
               end else begin
                  beat_d = beat_q + SEL_W'(1);
               end
            end
         end
         StCommit: begin
            commit  = 1'b1;
            beat_d  = '0;
            state_d = StAccum;
         end
         default: state_d = StAccum;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (err_clear) err_d = 1'b0;
      if (err_set)   err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StAccum;
         beat_q  <= '0;
         stage_q <= '0;
         core_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         stage_q <= stage_d;
         core_q  <= core_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

`ifdef CMD_MEM_READBACK_EN
   logic [MEM_TO_CMD-1:0][MEM_WIDTH-1:0] rb_cmd [ID_SPACE];
`endif

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      logic [CMD_WIDTH-1:0] mem [DEPTH];
      logic [CMD_WIDTH-1:0] rd1_q;

      // All banks of a command share one wide word, so a commit can never be partial.
      always_ff @(posedge clk) begin
         if (commit && (core_q == CORE_ID_WIDTH'(c))) begin
            mem[addr_q] <= stage_q;
         end
      end

      // Read-first: a read colliding with a commit sees the pre-commit word.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rd1_q <= '0;
         end else begin
            rd1_q <= mem[rd_addr[c*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH]];
         end
      end

      if (READ_LATENCY == 2) begin : g_lat2
         logic [CMD_WIDTH-1:0] rd2_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) rd2_q <= '0;
            else          rd2_q <= rd1_q;
         end
         assign rd_data[c*CMD_WIDTH +: CMD_WIDTH] = rd2_q;
      end else begin : g_lat1
         assign rd_data[c*CMD_WIDTH +: CMD_WIDTH] = rd1_q;
      end

`ifdef CMD_MEM_READBACK_EN
      logic [CMD_WIDTH-1:0] rb_cmd_q;
      always_ff @(posedge clk) begin
         if (rb_req) rb_cmd_q <= mem[rb_addr];
      end
      assign rb_cmd[c] = rb_cmd_q;
`endif
   end

`ifdef CMD_MEM_READBACK_EN
   for (genvar c = NUM_CORES; c < ID_SPACE; c++) begin : g_rb_pad
      assign rb_cmd[c] = '0;
   end

   logic [CORE_ID_WIDTH-1:0] rb_core_q;
   logic [SEL_W-1:0]         rb_sel_q;
   logic                     rb_v1_q;
   logic [MEM_WIDTH-1:0]     rb_word;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rb_core_q <= '0;
         rb_sel_q  <= '0;
         rb_v1_q   <= 1'b0;
      end else begin
         rb_v1_q <= rb_req;
         if (rb_req) begin
            rb_core_q <= rb_core;
            rb_sel_q  <= rb_sel;
         end
      end
   end

   always_comb begin
      rb_word = '0;
      if (rb_v1_q && core_ok[rb_core_q]) rb_word = rb_cmd[rb_core_q][rb_sel_q];
   end

   if (READ_LATENCY == 2) begin : g_rb_lat2
      logic [MEM_WIDTH-1:0] rb_data_q;
      logic                 rb_v2_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rb_data_q <= '0;
            rb_v2_q   <= 1'b0;
         end else begin
            rb_data_q <= rb_word;
            rb_v2_q   <= rb_v1_q;
         end
      end
      assign rb_data  = rb_data_q;
      assign rb_valid = rb_v2_q;
   end else begin : g_rb_lat1
      assign rb_data  = rb_word;
      assign rb_valid = rb_v1_q;
   end
`endif

endmodule

// File: tb/tb_cmd_mem_array.sv
// Directed bench for cmd_mem_array; read expectations go through a scoreboard queue.
// Readback checks are included when CMD_MEM_READBACK_EN is defined.
module tb_cmd_mem_array;

   localparam int NC = 2;
   localparam int AW = 8;
   localparam int MW = 32;
   localparam int MC = 4;
   localparam int CW = MW * MC;
   localparam int RL = 1;

   localparam logic [CW-1:0] C1   = 128'h44444444_33333333_22222222_11111111;
   localparam logic [CW-1:0] CA5  = {4{32'hA5A5A5A5}};
   localparam logic [CW-1:0] C3   = 128'h0C0C0C03_0C0C0C02_0C0C0C01_0C0C0C00;
   localparam logic [CW-1:0] CDE  = {4{32'hDEADBEEF}};
   localparam logic [CW-1:0] CNEW = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [CW-1:0] C5   = 128'h55550003_55550002_55550001_55550000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [0:0]        wr_core = '0;
   logic [AW-1:0]     wr_addr = '0;
   logic [MW-1:0]     wr_data = '0;
   logic              wr_last = 1'b0;
   logic              err;
   logic              err_clear = 1'b0;
   logic [NC*AW-1:0]  rd_addr = '0;
   logic [NC*CW-1:0]  rd_data;
`ifdef CMD_MEM_READBACK_EN
   logic              rb_req = 1'b0;
   logic [0:0]        rb_core = '0;
   logic [AW-1:0]     rb_addr = '0;
   logic [1:0]        rb_sel = '0;
   logic [MW-1:0]     rb_data;
   logic              rb_valid;
`endif

   always #5 clk = ~clk;

   cmd_mem_array #(
      .NUM_CORES(NC), .CORE_ID_WIDTH(1), .CMD_ADDR_WIDTH(AW),
      .MEM_WIDTH(MW), .MEM_TO_CMD(MC), .READ_LATENCY(RL)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_core   (wr_core),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_last   (wr_last),
      .err       (err),
      .err_clear (err_clear),
`ifdef CMD_MEM_READBACK_EN
      .rb_req    (rb_req),
      .rb_core   (rb_core),
      .rb_addr   (rb_addr),
      .rb_sel    (rb_sel),
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
`endif
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      int            core;
      logic [CW-1:0] data;
      string         tag;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input int core, input int addr, input logic [MW-1:0] data,
                            input bit last);
      int n = 0;
      wr_valid = 1'b1;
      wr_core  = 1'(core);
      wr_addr  = AW'(addr);
      wr_data  = data;
      wr_last  = last;
      while (!wr_ready && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!wr_ready) chk("ready_timeout", CW'(wr_ready), CW'(1));
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic write_cmd(input int core, input int addr, input logic [CW-1:0] cmd);
      for (int k = 0; k < MC; k++) send_beat(core, addr, cmd[k*MW +: MW], k == MC - 1);
      @(negedge clk);
      chk("commit_ready_low", CW'(wr_ready), CW'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input int core, input int addr, input logic [CW-1:0] exp,
                           input string tag);
      exp_t e;
      rd_addr[core*AW +: AW] = AW'(addr);
      e.core = core;
      e.data = exp;
      e.tag  = tag;
      sb.push_back(e);
      repeat (RL) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, rd_data[e.core*CW +: CW], e.data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("reset_wr_ready", CW'(wr_ready), CW'(1));
      chk("reset_err", CW'(err), CW'(0));
      chk("reset_rd0", rd_data[0 +: CW], '0);
      chk("reset_rd1", rd_data[CW +: CW], '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: basic write and read of core0
      write_cmd(0, 8'h05, C1);
      chk("t1_ready_back", CW'(wr_ready), CW'(1));
      rd_check(0, 8'h05, C1, "t1_core0_read");

      // 2: core1 same address is independent
      write_cmd(1, 8'h05, CA5);
      rd_check(0, 8'h05, C1, "t2_core0_kept");
      rd_check(1, 8'h05, CA5, "t2_core1_read");
      chk("t2_err", CW'(err), CW'(0));

      // 3: early wr_last drops the command and sets sticky err
      send_beat(0, 8'h05, 32'hBAD0BAD0, 1'b0);
      send_beat(0, 8'h05, 32'hBAD1BAD1, 1'b1);
      @(negedge clk);
      chk("t3_err_set", CW'(err), CW'(1));
      chk("t3_no_commit", CW'(wr_ready), CW'(1));
      rd_check(0, 8'h05, C1, "t3_mem_unchanged");
      write_cmd(1, 8'h20, C3);
      rd_check(1, 8'h20, C3, "t3_next_write");
      chk("t3_err_sticky", CW'(err), CW'(1));
      @(posedge clk);
      #1;
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      @(negedge clk);
      chk("t3_err_cleared", CW'(err), CW'(0));

      // 3b: missing wr_last on final beat, err_clear coinciding: set wins
      for (int k = 0; k < MC - 1; k++) send_beat(1, 8'h20, 32'h0BAD0000 + k, 1'b0);
      err_clear = 1'b1;
      send_beat(1, 8'h20, 32'h0BAD0003, 1'b0);
      err_clear = 1'b0;
      @(negedge clk);
      chk("t3b_set_wins", CW'(err), CW'(1));
      chk("t3b_no_commit", CW'(wr_ready), CW'(1));
      rd_check(1, 8'h20, C3, "t3b_mem_unchanged");

      // 4: read colliding with commit returns the old command
      write_cmd(0, 8'h10, CDE);
      for (int k = 0; k < MC; k++) send_beat(0, 8'h10, CNEW[k*MW +: MW], k == MC - 1);
      rd_check(0, 8'h10, CDE, "t4_collision_old");
      rd_check(0, 8'h10, CNEW, "t4_next_new");

      // 5: reset in the middle of a command
      for (int k = 0; k < MC - 1; k++) send_beat(0, 8'h05, 32'hF00D0000 + k, 1'b0);
      reset_n = 1'b0;
      #2;
      chk("t5_rd0_in_reset", rd_data[0 +: CW], '0);
      chk("t5_ready_in_reset", CW'(wr_ready), CW'(1));
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("t5_ready_after", CW'(wr_ready), CW'(1));
      chk("t5_err_after", CW'(err), CW'(0));
      rd_check(0, 8'h05, C1, "t5_mem_unchanged");
      @(posedge clk);
      #1;
      write_cmd(0, 8'h30, C5);
      rd_check(0, 8'h30, C5, "t5_fresh_write");
      chk("t5_err_final", CW'(err), CW'(0));

`ifdef CMD_MEM_READBACK_EN
      // 6: host readback of one bank
      @(posedge clk);
      #1;
      rb_req  = 1'b1;
      rb_core = 1'b0;
      rb_addr = 8'h05;
      rb_sel  = 2'd2;
      @(posedge clk);
      #1;
      rb_req = 1'b0;
      repeat (RL - 1) @(posedge clk);
      @(negedge clk);
      chk("t6_rb_valid", CW'(rb_valid), CW'(1));
      chk("t6_rb_data", CW'(rb_data), CW'(32'h33333333));
      @(negedge clk);
      chk("t6_rb_valid_pulse", CW'(rb_valid), CW'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
